// File: rtl/minmax_grant_sched.sv
// Four-requester min/max key scheduler: snapshot, arbitrate, grant handshake,
// then hold the shared resource until done or the watchdog expires.
module minmax_grant_sched #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] key,
    input  logic               tc,
    input  logic               max_mode,
    output logic               gnt_valid,
    output logic [1:0]         gnt_idx,
    output logic [3:0]         gnt_onehot,
    output logic [WIDTH-1:0]   gnt_key,
    input  logic               gnt_ack,
    output logic               busy,
    input  logic               done,
    output logic               timeout
);

    typedef enum logic [1:0] {IDLE, EVAL, GRANT, BUSY} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t             state, state_next;
    logic [3:0]         snap_req;
    logic [4*WIDTH-1:0] snap_key;
    logic               snap_tc;
    logic               snap_max;
    logic [15:0]        wd;
    logic               wd_expire;

    logic [1:0]         win_idx;
    logic [WIDTH-1:0]   win_key;
    logic [WIDTH-1:0]   best;
    logic [WIDTH-1:0]   ord;
    logic [WIDTH-1:0]   sign_flip;
    logic               found;

    // Flipping the MSB maps two's complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    always_comb begin
        win_idx   = '0;
        best      = '0;
        ord       = '0;
        found     = 1'b0;
        sign_flip = {snap_tc, {(WIDTH-1){1'b0}}};
        for (int unsigned i = 0; i < 4; i++) begin
            ord = snap_key[i*WIDTH +: WIDTH] ^ sign_flip;
            if (snap_req[i] && (!found || (snap_max ? (ord > best) : (ord < best)))) begin
                found   = 1'b1;
                best    = ord;
                win_idx = i[1:0];
            end
        end
        win_key = snap_key[win_idx*WIDTH +: WIDTH];
    end

    assign wd_expire = (state == BUSY) && !done && (wd == WD_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (|req) state_next = EVAL;
            EVAL:  state_next = GRANT;
            GRANT: if (gnt_ack) state_next = BUSY;
            BUSY:  if (done || wd_expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap_req   <= '0;
            snap_key   <= '0;
            snap_tc    <= 1'b0;
            snap_max   <= 1'b0;
            wd         <= '0;
            gnt_idx    <= '0;
            gnt_key    <= '0;
            gnt_onehot <= '0;
            timeout    <= 1'b0;
        end else begin
            state   <= state_next;
            timeout <= wd_expire;
            case (state)
                IDLE: begin
                    if (|req) begin
                        snap_req <= req;
                        snap_key <= key;
                        snap_tc  <= tc;
                        snap_max <= max_mode;
                    end
                end
                EVAL: begin
                    gnt_idx    <= win_idx;
                    gnt_key    <= win_key;
                    gnt_onehot <= 4'b0001 << win_idx;
                end
                GRANT: begin
                    if (gnt_ack) wd <= '0;
                end
                BUSY: begin
                    if (done || wd_expire) gnt_onehot <= '0;
                    else                   wd <= wd + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign gnt_valid = (state == GRANT);
    assign busy      = (state == BUSY);

endmodule
